// File: rtl/sram_device_model.sv
// sram_device_model: pin-level stand-in for the 16-bit asynchronous SRAM.
// Backs a reduced-depth on-chip array (upper address bits alias). Reads are
// captured one cycle after the address and driven onto Data in the next
// cycle. Writes commit on every WE-low cycle with per-byte lane enables.
// Also keeps access counters and a sticky protocol-violation flag for debug.
module sram_device_model #(
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic        clock_100,
  input  logic        reset,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        UB,
  input  logic        LB,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic [15:0] write_count,
  output logic [15:0] read_count,
  output logic        protocol_error
);

  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  // Byte-lane merge: a disabled lane (active-low enable high) keeps its old byte.
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_w,
                                              input logic [15:0] new_w,
                                              input logic        ub_n,
                                              input logic        lb_n);
    merge_lanes = {ub_n ? old_w[15:8] : new_w[15:8],
                   lb_n ? old_w[7:0]  : new_w[7:0]};
  endfunction

  logic [15:0]              mem [DEPTH];
  logic [MEM_ADDR_BITS-1:0] idx;

  logic [15:0] rd_reg;
  logic        rd_valid;
  logic        prev_we;
  logic [19:0] prev_addr;
  logic [15:0] prev_data;

  logic addr_xz;
  logic data_xz;
  logic wr_cyc;
  logic rd_cyc;
  logic wr_start;
  logic rd_start;
  logic unstable;
  logic drv_lo;
  logic drv_hi;
  logic drive_err;

  // Upper address bits are ignored for indexing, which gives the aliasing.
  assign idx = ADDR[MEM_ADDR_BITS-1:0];

  // Unknown address/data (e.g. controller floating its bus while idle) must
  // neither touch memory nor start a read nor raise the error flag.
  assign addr_xz = $isunknown(ADDR);
  assign data_xz = $isunknown(Data);

  assign wr_cyc   = !CE && !WE && !addr_xz && !data_xz;
  assign rd_cyc   = !CE &&  WE && !addr_xz;
  assign wr_start = !WE && prev_we;
  assign rd_start = rd_cyc && !rd_valid;

  // A write held across consecutive WE-low cycles must keep address and data.
  assign unstable = !WE && !prev_we && !addr_xz && !data_xz &&
                    ((ADDR != prev_addr) || (Data != prev_data));

  // Drive is gated by WE combinationally, so the bus is released in the very
  // cycle the controller starts a write (no contention in Write_1).
  assign drv_lo = rd_valid && !CE && !OE && WE && !LB;
  assign drv_hi = rd_valid && !CE && !OE && WE && !UB;

  // Safety net: the gating above makes this unreachable unless it is broken.
  assign drive_err = !WE && (drv_lo || drv_hi);

  assign Data[7:0]  = drv_lo ? rd_reg[7:0]  : 8'hzz;
  assign Data[15:8] = drv_hi ? rd_reg[15:8] : 8'hzz;

  // Memory array: lane-masked write on every qualified WE-low cycle; not reset.
  always_ff @(posedge clock_100) begin
    if (wr_cyc) begin
      mem[idx] <= merge_lanes(mem[idx], Data, UB, LB);
    end
  end

  // Read capture and write-stability history (datapath, not reset).
  always_ff @(posedge clock_100) begin
    if (rd_cyc) begin
      rd_reg <= mem[idx];
    end
    prev_addr <= ADDR;
    prev_data <= Data;
  end

  // Control state: read-valid, WE history, wrapping counters, sticky error.
  always_ff @(posedge clock_100) begin
    if (reset) begin
      rd_valid       <= 1'b0;
      prev_we        <= 1'b1;
      write_count    <= 16'h0000;
      read_count     <= 16'h0000;
      protocol_error <= 1'b0;
    end else begin
      rd_valid       <= rd_cyc;
      prev_we        <= WE;
      write_count    <= write_count + {15'd0, wr_start};
      read_count     <= read_count + {15'd0, rd_start};
      protocol_error <= protocol_error || unstable || drive_err;
    end
  end

endmodule

// File: tb/tb_sram_device_model.sv
// Bench for sram_device_model: directed bus cycles with a read scoreboard.
module tb_sram_device_model;

  logic        clock_100 = 1'b0;
  logic        reset;
  logic        CE, OE, WE, UB, LB;
  logic [19:0] ADDR;
  logic [15:0] tb_data;
  logic        tb_oe;
  wire  [15:0] Data;
  logic [15:0] write_count, read_count;
  logic        protocol_error;

  assign Data = tb_oe ? tb_data : 16'hzzzz;

  always #5 clock_100 = ~clock_100;

  sram_device_model #(.MEM_ADDR_BITS(12)) dut (
    .clock_100      (clock_100),
    .reset          (reset),
    .CE             (CE),
    .OE             (OE),
    .WE             (WE),
    .UB             (UB),
    .LB             (LB),
    .ADDR           (ADDR),
    .Data           (Data),
    .write_count    (write_count),
    .read_count     (read_count),
    .protocol_error (protocol_error)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        hi;
    logic        lo;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_wc;
  logic [15:0] exp_rc;
  logic        last_rd;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock_100);
    #1;
  endtask

  task automatic idle();
    CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1; tb_oe = 1'b0;
    tick();
    last_rd = 1'b0;
  endtask

  // Write_1 + Write_2 pair.
  task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    if (WE) exp_wc++;
    CE = 1'b0; OE = 1'b1; WE = 1'b0; UB = ub; LB = lb; ADDR = a;
    tb_data = d; tb_oe = 1'b1;
    tick();
    tick();
    last_rd = 1'b0;
  endtask

  // Read_1 + Read_2 pair; expected bus value pushed for the monitor.
  task automatic rd(input logic [19:0] a, input logic ub, input logic lb, input logic [15:0] expd);
    if (!last_rd) exp_rc++;
    sb.push_back('{d: expd, hi: !ub, lo: !lb});
    CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = ub; LB = lb; ADDR = a; tb_oe = 1'b0;
    tick();
    tick();
    last_rd = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    exp_wc = 16'h0000;
    exp_rc = 16'h0000;
  endtask

  // Monitor: bus must be free in WE-low cycles; any driven cycle pops one read.
  always @(negedge clock_100) begin
    if (!reset) begin
      if (!WE) begin
        n_checks++;
        if (dut.drv_lo || dut.drv_hi) begin
          n_fail++;
          $display("FAIL turnaround: model drives Data (lo=%0b hi=%0b) while WE=0, required none",
                   dut.drv_lo, dut.drv_hi);
        end
      end
      if (dut.drv_lo || dut.drv_hi) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_drive: Data=%h driven with no read pending", Data);
        end else begin
          mon_e = sb.pop_front();
          if ((dut.drv_lo != mon_e.lo) || (dut.drv_hi != mon_e.hi) ||
              (mon_e.lo && (Data[7:0] != mon_e.d[7:0])) ||
              (mon_e.hi && (Data[15:8] != mon_e.d[15:8]))) begin
            n_fail++;
            $display("FAIL read_data: got %h lanes hi/lo=%0b%0b expected %h lanes hi/lo=%0b%0b",
                     Data, dut.drv_hi, dut.drv_lo, mon_e.d, mon_e.hi, mon_e.lo);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
    ADDR = 20'h0; tb_data = 16'h0; tb_oe = 1'b0; last_rd = 1'b0;
    exp_wc = 16'h0; exp_rc = 16'h0;
    do_reset();
    idle();

    // Reset state
    chk("reset_write_count", write_count, 16'h0000);
    chk("reset_read_count", read_count, 16'h0000);
    chk("reset_protocol_error", {15'd0, protocol_error}, 16'h0000);
    chk("reset_bus_released", {14'd0, dut.drv_hi, dut.drv_lo}, 16'h0000);

    // Basic write then read
    wr(20'h00010, 16'hBEEF, 1'b0, 1'b0);
    rd(20'h00010, 1'b0, 1'b0, 16'hBEEF);
    idle();
    chk("basic_write_count", write_count, exp_wc);
    chk("basic_write_count_abs", write_count, 16'h0001);
    chk("basic_read_count", read_count, 16'h0001);

    // Lane-masked write over old data, then upper-lane-disabled read
    wr(20'h00020, 16'hAAAA, 1'b0, 1'b0);
    idle();
    wr(20'h00020, 16'h1234, 1'b0, 1'b1);
    rd(20'h00020, 1'b0, 1'b0, 16'h12AA);
    idle();
    rd(20'h00020, 1'b1, 1'b0, 16'h12AA);
    idle();

    // Aliasing of upper address bits
    wr(20'h01005, 16'h5555, 1'b0, 1'b0);
    idle();
    rd(20'h00005, 1'b0, 1'b0, 16'h5555);
    idle();

    // Turnaround: read straight into write, write straight into read
    rd(20'h00010, 1'b0, 1'b0, 16'hBEEF);
    wr(20'h00030, 16'hCAFE, 1'b0, 1'b0);
    rd(20'h00030, 1'b0, 1'b0, 16'hCAFE);
    idle();
    chk("turnaround_protocol_error", {15'd0, protocol_error}, 16'h0000);
    chk("mid_write_count", write_count, exp_wc);
    chk("mid_read_count", read_count, exp_rc);

    // Write counter wrap: preload near the top, then one more write pair
    force dut.write_count = 16'hFFFF;
    idle();
    release dut.write_count;
    idle();
    chk("wrap_preload", write_count, 16'hFFFF);
    wr(20'h00040, 16'h0F0F, 1'b0, 1'b0);
    idle();
    chk("wrap_write_count", write_count, 16'h0000);
    exp_wc = 16'h0000;
    chk("wrap_protocol_error", {15'd0, protocol_error}, 16'h0000);

    // Unstable write: address changes across the two WE-low cycles
    if (WE) exp_wc++;
    CE = 1'b0; OE = 1'b1; WE = 1'b0; UB = 1'b0; LB = 1'b0;
    ADDR = 20'h00001; tb_data = 16'h1111; tb_oe = 1'b1;
    tick();
    ADDR = 20'h00002;
    tick();
    idle();
    chk("unstable_protocol_error", {15'd0, protocol_error}, 16'h0001);
    idle();
    idle();
    idle();
    chk("sticky_protocol_error", {15'd0, protocol_error}, 16'h0001);
    chk("unstable_write_count", write_count, exp_wc);

    // Reset clears control state but keeps memory
    do_reset();
    chk("post_reset_protocol_error", {15'd0, protocol_error}, 16'h0000);
    chk("post_reset_write_count", write_count, 16'h0000);
    chk("post_reset_read_count", read_count, 16'h0000);
    rd(20'h00001, 1'b0, 1'b0, 16'h1111);
    idle();
    chk("retained_read_count", read_count, 16'h0001);
    chk("retained_write_count", write_count, exp_wc);
    idle();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d reads never driven, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
